// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time loader that packs a little-endian byte stream
// into 32-bit words, writes them into instruction memory and holds the core
// in reset until a complete load has finished.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle load request, honoured only in IDLE
//   num_words  number of words to load (1..DEPTH), latched on accepted start
//   byte_valid byte_data carries a valid byte
//   byte_data  stream byte
//   byte_ready loader accepts a byte this cycle (LOAD only)
//   mem_we     instruction-memory write enable, one cycle per word
//   mem_addr   word address of the write
//   mem_wdata  assembled instruction word
//   core_hold  1 = keep the core in reset
//   busy       high in LOAD and WRITE
//   done       one-cycle pulse after the final word is written
//   err        one-cycle pulse on a rejected start
module instr_mem_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CW    = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     num_q, num_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       asm_q, asm_d;
    logic              byte_ready_q, byte_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              core_hold_q, core_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so that every output comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        wcnt_d       = wcnt_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        byte_ready_d = byte_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_hold_d  = core_hold_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((num_words != '0) && (num_words <= CW'(DEPTH))) begin
                        num_d        = num_words;
                        wcnt_d       = '0;
                        idx_d        = '0;
                        asm_d        = '0;
                        core_hold_d  = 1'b1;
                        busy_d       = 1'b1;
                        byte_ready_d = 1'b1;
                        state_d      = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (byte_valid && byte_ready_q) begin
                    // First byte of a word lands in the LSB.
                    case (idx_q)
                        2'd0:    asm_d[7:0]   = byte_data;
                        2'd1:    asm_d[15:8]  = byte_data;
                        2'd2:    asm_d[23:16] = byte_data;
                        default: asm_d[31:24] = byte_data;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d      = S_WRITE;
                        mem_we_d     = 1'b1;
                        mem_addr_d   = wcnt_q[ADDR_W-1:0];
                        mem_wdata_d  = {byte_data, asm_q[23:0]};
                        byte_ready_d = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                // Counter is one bit wider than the address so a full-depth
                // load can be compared against num_words without wrapping.
                wcnt_d = wcnt_q + CW'(1);
                if (wcnt_d == num_q) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    core_hold_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    state_d      = S_LOAD;
                    idx_d        = '0;
                    byte_ready_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            wcnt_q       <= '0;
            idx_q        <= '0;
            asm_q        <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_hold_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            wcnt_q       <= wcnt_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_hold_q  <= core_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_hold  = core_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader (ADDR_W = 6).
module tb_instr_mem_loader;

    localparam int unsigned AW = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW:0]   num_words;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;

    instr_mem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/pulse monitor sampled on the falling edge.
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   rdy_bad = 0;
    int   last_we_cyc = 0;
    int   done_cyc = 0;
    logic hold_at_we = 1'b0;
    logic hold_at_done = 1'b1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            last_we_cyc = cyc;
            hold_at_we  = core_hold;
            if (byte_ready) rdy_bad = rdy_bad + 1;
        end
        if (busy && !mem_we && !byte_ready) rdy_bad = rdy_bad + 1;
        if (!busy && byte_ready) rdy_bad = rdy_bad + 1;
        if (done) begin
            done_cnt     = done_cnt + 1;
            done_cyc     = cyc;
            hold_at_done = core_hold;
        end
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        rdy_bad  = 0;
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            errors++;
            $display("FAIL send_byte timeout: byte_ready=%b required 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [AW:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL wait_done timeout: done_cnt=%0d required >0", done_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({byte_ready, mem_we, busy, done, err, core_hold} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000001",
                     {byte_ready, mem_we, busy, done, err, core_hold});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h data=%h required 0", mem_addr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({byte_ready, busy, core_hold} !== 3'b001) begin
            errors++;
            $display("FAIL reset_held: got %b required 001", {byte_ready, busy, core_hold});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] bytes [8];
        bytes = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
        clear_mon();
        do_start(7'd2);
        checks++;
        if ({busy, byte_ready, core_hold} !== 3'b111) begin
            errors++;
            $display("FAIL basic_start: busy/rdy/hold=%b required 111", {busy, byte_ready, core_hold});
        end
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        wait_done();
        checks++;
        if (wa_q.size() !== 2) begin
            errors++;
            $display("FAIL basic_nwrites: got %0d required 2", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 6'd0 || wd_q[0] !== 32'h00100513) begin
                errors++;
                $display("FAIL basic_w0: addr=%0d data=%h required 0 00100513", wa_q[0], wd_q[0]);
            end
            checks++;
            if (wa_q[1] !== 6'd1 || wd_q[1] !== 32'h00B505B3) begin
                errors++;
                $display("FAIL basic_w1: addr=%0d data=%h required 1 00b505b3", wa_q[1], wd_q[1]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_we_cyc + 1) begin
            errors++;
            $display("FAIL basic_done: cnt=%0d gap=%0d required 1 1", done_cnt, done_cyc - last_we_cyc);
        end
        checks++;
        if (hold_at_we !== 1'b1 || hold_at_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: at_we=%b at_done=%b required 1 0", hold_at_we, hold_at_done);
        end
        checks++;
        if ({core_hold, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL basic_idle: hold/busy/done=%b required 000", {core_hold, busy, done});
        end
    endtask

    task automatic test_gaps();
        logic [7:0] bytes [8];
        int gaps [8];
        bytes = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
        gaps  = '{0, 3, 1, 0, 3, 2, 0, 3};
        clear_mon();
        do_start(7'd2);
        for (int i = 0; i < 8; i++) begin
            repeat (gaps[i] + int'($urandom_range(0, 1))) @(negedge clk);
            send_byte(bytes[i]);
        end
        wait_done();
        checks++;
        if (wa_q.size() !== 2) begin
            errors++;
            $display("FAIL gaps_nwrites: got %0d required 2", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 6'd0 || wd_q[0] !== 32'h00100513 ||
                wa_q[1] !== 6'd1 || wd_q[1] !== 32'h00B505B3) begin
                errors++;
                $display("FAIL gaps_data: %0d:%h %0d:%h required 0:00100513 1:00b505b3",
                         wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
            end
        end
        checks++;
        if (rdy_bad !== 0) begin
            errors++;
            $display("FAIL gaps_ready: violations=%0d required 0", rdy_bad);
        end
    endtask

    task automatic test_bad_start();
        logic [AW:0] bad [2];
        bad = '{7'd0, 7'd65};
        clear_mon();
        for (int i = 0; i < 2; i++) begin
            do_start(bad[i]);
            checks++;
            if ({err, busy, byte_ready, mem_we, core_hold} !== 5'b10000) begin
                errors++;
                $display("FAIL bad_start_%0d: err/busy/rdy/we/hold=%b required 10000",
                         bad[i], {err, busy, byte_ready, mem_we, core_hold});
            end
            @(negedge clk);
            checks++;
            if ({err, busy} !== 2'b00) begin
                errors++;
                $display("FAIL bad_after_%0d: err/busy=%b required 00", bad[i], {err, busy});
            end
        end
        checks++;
        if (err_cnt !== 2 || wa_q.size() !== 0) begin
            errors++;
            $display("FAIL bad_totals: errs=%0d writes=%0d required 2 0", err_cnt, wa_q.size());
        end
    endtask

    task automatic test_full();
        logic [31:0] exp;
        int bad = 0;
        clear_mon();
        do_start(7'd64);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        wait_done();
        repeat (5) @(negedge clk);
        checks++;
        if (wa_q.size() !== 64) begin
            errors++;
            $display("FAIL full_nwrites: got %0d required 64", wa_q.size());
        end else begin
            for (int k = 0; k < 64; k++) begin
                exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
                checks++;
                if (wa_q[k] !== 6'(k) || wd_q[k] !== exp) begin
                    errors++;
                    bad++;
                    if (bad < 5)
                        $display("FAIL full_w%0d: addr=%0d data=%h required %0d %h",
                                 k, wa_q[k], wd_q[k], k, exp);
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || mem_addr !== 6'd63 || mem_wdata !== 32'hFFFEFDFC) begin
            errors++;
            $display("FAIL full_end: done=%0d addr=%0d data=%h required 1 63 fffefdfc",
                     done_cnt, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_restart_ignored();
        logic [7:0] bytes [8];
        bytes = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
        clear_mon();
        do_start(7'd2);
        send_byte(bytes[0]);
        send_byte(bytes[1]);
        do_start(7'd5);
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL restart_busy: busy/err=%b required 10", {busy, err});
        end
        for (int i = 2; i < 8; i++) send_byte(bytes[i]);
        wait_done();
        repeat (10) @(negedge clk);
        checks++;
        if (wa_q.size() !== 2 || done_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_count: writes=%0d done=%0d busy=%b required 2 1 0",
                     wa_q.size(), done_cnt, busy);
        end else begin
            checks++;
            if (wd_q[0] !== 32'h00100513 || wd_q[1] !== 32'h00B505B3) begin
                errors++;
                $display("FAIL restart_data: %h %h required 00100513 00b505b3", wd_q[0], wd_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        do_start(7'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({byte_ready, mem_we, busy, done, err, core_hold} !== 6'b000001 ||
            mem_addr !== 6'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b addr=%0d data=%h required 000001 0 0",
                     {byte_ready, mem_we, busy, done, err, core_hold}, mem_addr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, byte_ready, core_hold} !== 3'b001 || wa_q.size() !== 0) begin
            errors++;
            $display("FAIL mid_after: busy/rdy/hold=%b writes=%0d required 001 0",
                     {busy, byte_ready, core_hold}, wa_q.size());
        end
        do_start(7'd1);
        send_byte(8'h33);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done();
        checks++;
        if (wa_q.size() !== 1) begin
            errors++;
            $display("FAIL mid_nwrites: got %0d required 1", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 6'd0 || wd_q[0] !== 32'h00000033) begin
                errors++;
                $display("FAIL mid_w0: addr=%0d data=%h required 0 00000033", wa_q[0], wd_q[0]);
            end
        end
        checks++;
        if (core_hold !== 1'b0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL mid_done: hold=%b done=%0d required 0 1", core_hold, done_cnt);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        num_words  = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        test_reset();
        test_basic();
        test_gaps();
        test_bad_start();
        test_full();
        test_restart_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Boot-time loader that fills the instruction memory before the pipelined core runs. It accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit instruction words. It drives the instruction-memory write port and holds the core in reset until a load completes. It sits between the host/debug link and the write side of instruction memory; the core's fetch path is the read side of that memory.

Parameters:
ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words (default 64).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE
num_words  input  ADDR_W+1  words to load; latched on an accepted start; legal range 1..DEPTH
byte_valid  input  1  byte_data holds a valid byte
byte_data  input  8  stream byte
byte_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction-memory write enable, one cycle per word
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  instruction word
core_hold  output  1  1 = keep core in reset (combine externally with rst)
busy  output  1  high in LOAD and WRITE
done  output  1  one-cycle pulse when the final word has been written
err  output  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; byte_ready=0; mem_we=0; mem_addr=0; mem_wdata=0; busy=0; done=0; err=0; core_hold=1. Internal byte index, word counter and assembly register clear to 0.
- A reset mid-load discards any partial word. Words already written stay in memory. The next load starts at address 0.
- FSM has four states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - byte_ready=0.
  - If start=1 and num_words is in 1..DEPTH: latch num_words, clear byte index and word address, go to LOAD.
  - If start=1 and num_words is 0 or greater than DEPTH: err=1 for the next cycle, stay in IDLE, core_hold unchanged.
- LOAD:
  - byte_ready=1, core_hold=1.
  - A byte is accepted on a rising edge where byte_valid & byte_ready.
  - Byte index k (0..3) writes bits [8k+7:8k] of the assembly register, so the first byte is the LSB.
  - When byte index 3 is accepted, go to WRITE. Idle cycles (byte_valid=0) change nothing.
- WRITE (exactly one cycle):
  - mem_we=1; mem_addr = current word address; mem_wdata = assembled word; byte_ready=0.
  - Latency: mem_we is asserted in the cycle immediately after the 4th byte is accepted.
  - Then increment the word address. If the number of words written equals num_words, go to DONE; otherwise return to LOAD with byte index 0.
- DONE (one cycle): done=1; core_hold=0; busy=0; then go to IDLE.
- core_hold:
  - Stays 0 in IDLE after a successful load.
  - Returns to 1 on the cycle after the next accepted start.
  - After reset it stays 1 until the first successful load.
- Address rules:
  - mem_addr never wraps. A load of DEPTH words ends at address DEPTH-1.
  - The counter needs ADDR_W+1 bits for the comparison against num_words.
- start is ignored outside IDLE, including while busy.
- mem_wdata and mem_addr hold their last values outside WRITE; only mem_we qualifies them.
- No output has a combinational path from byte_valid; byte_ready depends only on state.

Test Plan:
1. Release rst, pulse start with num_words=2, send bytes 13 05 10 00 B3 05 B5 00 back-to-back -> mem_we at addr 0 with 0x00100513, then at addr 1 with 0x00B505B3. done pulses one cycle after the second write; core_hold goes 1->0 in that same cycle.
2. Same 2-word load with byte_valid toggled 0/1 at random and 3-cycle gaps -> identical writes and data. byte_ready=0 only in the WRITE cycles and in IDLE.
3. start with num_words=0, then with num_words=65 (ADDR_W=6) -> err pulse each time, no mem_we, busy=0, state stays IDLE.
4. num_words=64 with an incrementing byte pattern -> 64 writes at addrs 0..63, last data 0xFFFEFDFC, no write at address 0 after the last one, done once.
5. During a load, assert rst after 2 bytes, release it, then run a 1-word load of 0x00000033 -> all outputs at reset values while rst=0, core_hold=1, and a single write of 0x00000033 at addr 0.
6. Pulse start again mid-load with num_words=5 -> ignored: the original num_words=2 completes with exactly 2 writes.
